mem_stage: RTL

Memory-access stage of the pipelined RV32I core, directly downstream of the execute stage. Consumes the EX/MEM pipeline register outputs, performs the load/store through a req/ack data-memory port with byte-lane alignment and sign/zero extension, stalls the pipeline while an access is outstanding, and holds the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/lsu_align.sv | 64 ++++++
 rtl/mem_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and state type for the memory-access stage.
// Opcode/funct3 encodings follow the RV32I base ISA.
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data-memory port: store lane replication and
// byte enables, load extraction with sign/zero extension, and misalign detection.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] shifted;

    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case statements so no
        // path leaves a value unassigned, which would otherwise infer a latch.
        wdata     = store_data;
        be        = 4'b1111;
        load_data = load_word;
        misalign  = 1'b0;

        if (is_store) begin
            case (funct3)
                F3_B: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << offset;
                end
                F3_H: begin
                    wdata = {2{store_data[15:0]}};
                    be    = 4'b0011 << offset;
                end
                F3_W:    misalign = |offset;
                default: ;
            endcase
            if (funct3 == F3_H) begin
                misalign = offset[0];
            end
        end

        if (is_load) begin
            case (funct3)
                F3_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
                F3_BU: load_data = {24'b0, shifted[7:0]};
                F3_HU: load_data = {16'b0, shifted[15:0]};
                default: ;
            endcase
            case (funct3)
                F3_H, F3_HU: misalign = offset[0];
                F3_W:        misalign = |offset;
                default:     ;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: req/ack data-memory handshake FSM, captured read
// data for accesses that complete while the pipeline is held, and the MEM/WB register.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_mem_i,
    input  logic [31:0] rs2_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic        MemRW_mem_i,
    input  logic [1:0]  WBSel_mem_i,
    input  logic        RegWEn_mem_i,
    input  logic [4:0]  rsW_mem_i,
    input  logic [31:0] inst_mem_i,
    input  logic        enable_i,
    input  logic        reset_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_stall_o,
    output logic        misalign_o,
    output logic [31:0] alu_wb_o,
    output logic [31:0] ld_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [31:0] inst_wb_o,
    output logic [1:0]  WBSel_wb_o,
    output logic        RegWEn_wb_o,
    output logic [4:0]  rsW_wb_o
);

    mem_state_e  state_q;
    logic [31:0] cap_q;
    logic [31:0] req_addr_q;
    logic        req_we_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_be_q;

    logic        is_load;
    logic        is_store;
    logic        aligned_op;
    logic        advance;
    logic [31:0] addr_c;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_load;
    logic [31:0] load_word;
    logic        req_c;

    assign is_load  = (inst_mem_i[6:0] == OP_LOAD);
    assign is_store = (inst_mem_i[6:0] == OP_STORE) && MemRW_mem_i;
    assign addr_c   = {alu_mem_i[31:2], 2'b00};

    // Once an access has completed with the pipeline held, the word lives in cap_q.
    assign load_word = (state_q == DONE) ? cap_q : dmem_rdata_i;

    lsu_align u_lsu_align (
        .funct3     (inst_mem_i[14:12]),
        .offset     (alu_mem_i[1:0]),
        .is_load    (is_load),
        .is_store   (is_store),
        .store_data (rs2_mem_i),
        .load_word  (load_word),
        .wdata      (lsu_wdata),
        .be         (lsu_be),
        .load_data  (lsu_load),
        .misalign   (misalign_o)
    );

    assign aligned_op = (is_load || is_store) && !misalign_o;

    // While waiting, the request comes from the registered copy so a flush or
    // a change upstream cannot disturb an access the memory has already seen.
    always_comb begin
        req_c        = 1'b0;
        dmem_addr_o  = addr_c;
        dmem_wdata_o = lsu_wdata;
        dmem_be_o    = lsu_be;
        dmem_we_o    = is_store;
        case (state_q)
            IDLE: req_c = aligned_op;
            WAIT: begin
                req_c        = 1'b1;
                dmem_addr_o  = req_addr_q;
                dmem_wdata_o = req_wdata_q;
                dmem_be_o    = req_be_q;
                dmem_we_o    = req_we_q;
            end
            default: ;
        endcase
        dmem_req_o = req_c && !rst_i;
        dmem_we_o  = dmem_we_o && dmem_req_o;
    end

    assign mem_stall_o = dmem_req_o && !dmem_ack_i;
    assign advance     = enable_i && !mem_stall_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aligned_op) begin
                        if (dmem_ack_i) begin
                            cap_q <= dmem_rdata_i;
                            if (!enable_i) begin
                                state_q <= DONE;
                            end
                        end else begin
                            state_q     <= WAIT;
                            req_addr_q  <= addr_c;
                            req_we_q    <= is_store;
                            req_wdata_q <= lsu_wdata;
                            req_be_q    <= lsu_be;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack_i) begin
                        cap_q   <= dmem_rdata_i;
                        state_q <= enable_i ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (enable_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A misaligned load never read memory, so it writes zero like a non-load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_wb_o    <= '0;
            ld_wb_o     <= '0;
            pc4_wb_o    <= '0;
            inst_wb_o   <= '0;
            WBSel_wb_o  <= '0;
            RegWEn_wb_o <= 1'b0;
            rsW_wb_o    <= '0;
        end else if (advance) begin
            if (reset_i) begin
                alu_wb_o    <= '0;
                ld_wb_o     <= '0;
                pc4_wb_o    <= '0;
                inst_wb_o   <= '0;
                WBSel_wb_o  <= '0;
                RegWEn_wb_o <= 1'b0;
                rsW_wb_o    <= '0;
            end else begin
                alu_wb_o    <= alu_mem_i;
                ld_wb_o     <= (is_load && !misalign_o) ? lsu_load : 32'h0;
                pc4_wb_o    <= pc4_mem_i;
                inst_wb_o   <= inst_mem_i;
                WBSel_wb_o  <= WBSel_mem_i;
                RegWEn_wb_o <= RegWEn_mem_i && !misalign_o;
                rsW_wb_o    <= rsW_mem_i;
            end
        end
    end

endmodule
